fpaddsub_align_shift_pipe: RTL and testbench
============================================

Name: fpaddsub_align_shift_pipe

Overview:
- Pipelined right-shift alignment unit for the FP add/sub datapath. Mirrors the left normalization shift.
- Shifts the smaller mantissa right by the exponent difference before the add. Produces guard, round and sticky bits.
- Two register stages: coarse shift (multiples of 4), then fine shift (0–3). Valid/ready handshake on both sides. A sideband tag (aligned exponent) passes through in lockstep.

Parameters:
- MW, 24, mantissa width in bits, including the hidden bit.
- SW, 5, shift-amount width. Must satisfy 2^SW ≥ MW+3.
- TW, 8, sideband tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- in_mant  in  MW  mantissa to be aligned.
- in_shift  in  SW  right-shift amount (exponent difference).
- in_tag  in  TW  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_mant  out  MW  aligned mantissa.
- out_g  out  1  guard bit.
- out_r  out  1  round bit.
- out_s  out  1  sticky bit.
- out_tag  out  TW  tag of the beat on the output.

Behaviour:
- Arithmetic:
  - ext = {in_mant, 3'b000}, width MW+3. res = ext >> in_shift.
  - out_mant = res[MW+2:3], out_g = res[2], out_r = res[1].
  - out_s = res[0] OR (OR of every ext bit shifted out below bit 0).
- Saturation: if in_shift ≥ MW+3, then out_mant = 0, g = 0, r = 0, s = |in_mant. No wrap or modulo of the shift amount.
- Stage 1, registered on acceptance:
  - Coarse shift of ext by 4·in_shift[SW-1:2].
  - Records partial sticky = OR of bits dropped.
  - Holds in_shift[1:0], the tag, and a saturation flag.
- Stage 2, registered:
  - Fine shift by 0–3.
  - Dropped bits are ORed with the stage-1 partial sticky into out_s.
  - Saturation flag overrides the result as above.
- Handshake:
  - Input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
  - s2 advances when !s2_valid || out_ready. s1 advances when !s1_valid || s2 advances.
  - in_ready = !s1_valid || s2 advances. This is combinational from out_ready; there is no skid buffer.
- Latency and throughput:
  - 2 cycles from acceptance to out_valid when not stalled.
  - 1 beat/cycle sustained throughput with out_ready held high.
- Stall: while out_valid && !out_ready, every out_* signal holds stable. Stage 1 holds if occupied. No beat is lost or duplicated.
- Simultaneous accept and consume: when s2 is consumed in the same cycle s1 moves into s2 and a new beat enters s1, all three transfers happen in that one cycle.
- Reset (async, takes effect immediately, including mid-operation):
  - s1_valid = 0, s2_valid = 0, out_valid = 0.
  - out_mant = 0, out_g = out_r = out_s = 0, out_tag = 0.
  - All in-flight beats are discarded.
- After reset deassertion, in_ready = 1.
- Data registers do not capture when their stage is not advancing.
- out_* values are don't-care when out_valid = 0, except immediately after reset (all 0).

Test Plan (MW=24, SW=5):
- Zero shift: mant 0x800001, shift 0, tag 0x7F → after 2 cycles out_mant 0x800001, g/r/s 0/0/0, tag 0x7F.
- Fine shift: mant 0x800001, shift 2 → out_mant 0x200000, g=0, r=1, s=0.
- Sticky accumulation across stages: mant 0x00000F, shift 4 → out_mant 0x000000, g=1, r=1, s=1.
- Saturation boundary:
  - shift 26, mant 0x800000 → mant 0, g=0, r=0, s=1.
  - shift 27 and shift 31 with the same mant → mant 0, s=1.
  - mant 0, shift 31 → all outputs 0.
- Backpressure:
  - Stream 6 beats with out_ready low for cycles 3–6 → in_ready drops once both stages are full.
  - Outputs stay stable during the stall.
  - All 6 beats emerge in order with correct tags, with no gaps once out_ready returns.
- Reset mid-stream: assert rst while 2 beats are in flight → out_valid falls immediately, outputs read 0, in_ready = 1 after release, and no stale beat appears later.

Source files
------------

// File: rtl/fpaddsub_align_shift_pipe.sv
// Two-stage right-shift alignment for the FP add/sub datapath: coarse shift by
// multiples of four, then a fine shift of 0-3, producing guard/round/sticky.
module fpaddsub_align_shift_pipe #(
    parameter int MW = 24,
    parameter int SW = 5,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] in_mant,
    input  logic [SW-1:0] in_shift,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_mant,
    output logic          out_g,
    output logic          out_r,
    output logic          out_s,
    output logic [TW-1:0] out_tag
);

    localparam int EW = MW + 3;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv    = !s2_valid_reg || out_ready;
    assign s1_adv    = !s1_valid_reg || s2_adv;
    assign in_ready  = s1_adv;
    assign accept    = in_valid && s1_adv;
    assign out_valid = s2_valid_reg;

    // ------------------------------------------------------------------
    // Stage 1 combinational: coarse shift of the extended mantissa
    // ------------------------------------------------------------------
    logic [EW-1:0]   ext;
    logic [SW-1:0]   coarse_amt;
    logic [2*EW-1:0] coarse_wide;
    logic [EW-1:0]   coarse_ext;
    logic            coarse_drop;
    logic            sat;

    assign ext        = {in_mant, 3'b000};
    assign coarse_amt = {in_shift[SW-1:2], 2'b00};
    // The lower half of the widened vector collects exactly the bits shifted out.
    assign coarse_wide = {ext, {EW{1'b0}}} >> coarse_amt;
    assign coarse_ext  = coarse_wide[2*EW-1:EW];
    assign coarse_drop = |coarse_wide[EW-1:0];
    assign sat         = (32'(in_shift) >= EW);

    logic [EW-1:0] s1_ext_reg;
    logic          s1_sticky_reg;
    logic [1:0]    s1_fine_reg;
    logic [TW-1:0] s1_tag_reg;
    logic          s1_sat_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_ext_reg    <= '0;
            s1_sticky_reg <= 1'b0;
            s1_fine_reg   <= 2'b00;
            s1_tag_reg    <= '0;
            s1_sat_reg    <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= accept;
            end
            if (accept) begin
                s1_fine_reg <= in_shift[1:0];
                s1_tag_reg  <= in_tag;
                s1_sat_reg  <= sat;
                // A saturating beat keeps only the "any bit set" sticky.
                if (sat) begin
                    s1_ext_reg    <= '0;
                    s1_sticky_reg <= |in_mant;
                end else begin
                    s1_ext_reg    <= coarse_ext;
                    s1_sticky_reg <= coarse_drop;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: fine shift of 0-3
    // ------------------------------------------------------------------
    logic [EW+2:0] fine_wide;
    logic [EW-1:0] fine_res;
    logic          fine_drop;
    logic [MW-1:0] mant_next;
    logic          g_next;
    logic          r_next;
    logic          s_next;

    assign fine_wide = {s1_ext_reg, 3'b000} >> s1_fine_reg;
    assign fine_res  = fine_wide[EW+2:3];
    assign fine_drop = |fine_wide[2:0];

    always_comb begin
        mant_next = fine_res[EW-1:3];
        g_next    = fine_res[2];
        r_next    = fine_res[1];
        s_next    = fine_res[0] | fine_drop | s1_sticky_reg;
        if (s1_sat_reg) begin
            mant_next = '0;
            g_next    = 1'b0;
            r_next    = 1'b0;
            s_next    = s1_sticky_reg;
        end
    end

    logic [MW-1:0] s2_mant_reg;
    logic          s2_g_reg;
    logic          s2_r_reg;
    logic          s2_s_reg;
    logic [TW-1:0] s2_tag_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_mant_reg  <= '0;
            s2_g_reg     <= 1'b0;
            s2_r_reg     <= 1'b0;
            s2_s_reg     <= 1'b0;
            s2_tag_reg   <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_mant_reg <= mant_next;
                s2_g_reg    <= g_next;
                s2_r_reg    <= r_next;
                s2_s_reg    <= s_next;
                s2_tag_reg  <= s1_tag_reg;
            end
        end
    end

    assign out_mant = s2_mant_reg;
    assign out_g    = s2_g_reg;
    assign out_r    = s2_r_reg;
    assign out_s    = s2_s_reg;
    assign out_tag  = s2_tag_reg;

endmodule

// File: tb/tb_fpaddsub_align_shift_pipe.sv
// Scoreboard bench for the two-stage alignment shifter: directed vectors,
// back-to-back streaming, random handshakes, backpressure and mid-stream reset.
module tb_fpaddsub_align_shift_pipe;

    localparam int MW = 24;
    localparam int SW = 5;
    localparam int TW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_mant;
    logic [SW-1:0] in_shift;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_mant;
    logic          out_g;
    logic          out_r;
    logic          out_s;
    logic [TW-1:0] out_tag;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [MW-1:0] mant;
        logic          g;
        logic          r;
        logic          s;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];

    fpaddsub_align_shift_pipe #(.MW(MW), .SW(SW), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_shift  (in_shift),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_g     (out_g),
        .out_r     (out_r),
        .out_s     (out_s),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width shift with an explicit mask for the lost bits.
    function automatic exp_t model(input logic [MW-1:0] m, input logic [SW-1:0] sh,
                                   input logic [TW-1:0] t);
        exp_t e;
        logic [63:0] ext;
        logic [63:0] res;
        logic [63:0] lost;
        ext = 64'(m) << 3;
        e.tag = t;
        if (int'(sh) >= MW + 3) begin
            e.mant = '0;
            e.g = 1'b0;
            e.r = 1'b0;
            e.s = (m != 0);
        end else begin
            res  = ext >> sh;
            lost = ext & ((64'd1 << sh) - 64'd1);
            e.mant = res[MW+2:3];
            e.g = res[2];
            e.r = res[1];
            e.s = res[0] | (lost != 0);
        end
        return e;
    endfunction

    localparam int ND = 9;
    localparam logic [MW-1:0] DIR_MANT  [ND] = '{24'h800001, 24'h800001, 24'h00000F, 24'h800000,
                                                 24'h800000, 24'h800000, 24'h000000, 24'hFFFFFF, 24'h800000};
    localparam logic [SW-1:0] DIR_SHIFT [ND] = '{5'd0, 5'd2, 5'd4, 5'd26, 5'd27, 5'd31, 5'd31, 5'd25, 5'd3};
    localparam logic [TW-1:0] DIR_TAG   [ND] = '{8'h7F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    localparam logic [MW-1:0] EXP_MANT  [ND] = '{24'h800001, 24'h200000, 24'h000000, 24'h000000,
                                                 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h100000};
    localparam logic [2:0]    EXP_GRS   [ND] = '{3'b000, 3'b010, 3'b111, 3'b001, 3'b001, 3'b001, 3'b000, 3'b011, 3'b000};

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_mant = '0;
        in_shift = '0;
        in_tag = '0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({out_valid, out_mant, out_g, out_r, out_s, out_tag} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b mant=%h grs=%b%b%b tag=%h required all 0",
                     out_valid, out_mant, out_g, out_r, out_s, out_tag);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
        $display("test_reset done");
    endtask

    // Directed vectors streamed back to back with hard-coded expectations.
    task automatic test_back_to_back();
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int first_out = -1;
        int last_out = -1;
        exp_t e;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mant = DIR_MANT[0];
        in_shift = DIR_SHIFT[0];
        in_tag = DIR_TAG[0];
        while (got < ND && cyc < 100) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL directed_unexpected got tag=%h required no beat", out_tag);
                end else begin
                    e = sb.pop_front();
                    if ({out_mant, out_g, out_r, out_s, out_tag} !== e) begin
                        failures++;
                        $display("FAIL directed_beat%0d got mant=%h grs=%b%b%b tag=%h required mant=%h grs=%b%b%b tag=%h",
                                 got, out_mant, out_g, out_r, out_s, out_tag, e.mant, e.g, e.r, e.s, e.tag);
                    end
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                e.mant = EXP_MANT[idx];
                e.g = EXP_GRS[idx][2];
                e.r = EXP_GRS[idx][1];
                e.s = EXP_GRS[idx][0];
                e.tag = DIR_TAG[idx];
                sb.push_back(e);
                $display("directed push idx=%0d mant=%h shift=%0d tag=%h", idx, in_mant, in_shift, in_tag);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < ND) begin
                in_mant = DIR_MANT[idx];
                in_shift = DIR_SHIFT[idx];
                in_tag = DIR_TAG[idx];
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        checks++;
        if (got != ND) begin
            failures++;
            $display("FAIL directed_timeout got %0d beats required %0d", got, ND);
        end
        checks++;
        if (first_out != 2) begin
            failures++;
            $display("FAIL directed_latency got first output cycle %0d required 2", first_out);
        end
        checks++;
        if (last_out != ND + 1) begin
            failures++;
            $display("FAIL directed_throughput got last output cycle %0d required %0d", last_out, ND + 1);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = ($urandom_range(0, 9) < 7);
        in_mant = MW'($urandom);
        in_shift = SW'($urandom_range(0, 31));
        in_tag = TW'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        while ((sent < 150 || got < sent) && cyc < 2000) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL random_unexpected got tag=%h required no beat", out_tag);
                end else begin
                    e = sb.pop_front();
                    if ({out_mant, out_g, out_r, out_s, out_tag} !== e) begin
                        failures++;
                        $display("FAIL random_beat%0d got mant=%h grs=%b%b%b tag=%h required mant=%h grs=%b%b%b tag=%h",
                                 got, out_mant, out_g, out_r, out_s, out_tag, e.mant, e.g, e.r, e.s, e.tag);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_mant, in_shift, in_tag));
                $display("random push n=%0d mant=%h shift=%0d tag=%h", sent, in_mant, in_shift, in_tag);
                sent++;
            end
            @(posedge clk);
            #1;
            in_valid = (sent < 150) && ($urandom_range(0, 9) < 7);
            in_mant = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(0, 255)) : MW'($urandom);
            in_shift = SW'($urandom_range(0, 31));
            in_tag = TW'($urandom);
            out_ready = (sent >= 150) || ($urandom_range(0, 9) < 7);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 150 || sb.size() != 0) begin
            failures++;
            $display("FAIL random_count got %0d beats (%0d pending) required 150", got, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int got = 0;
        int cyc = 0;
        bit saw_block = 0;
        bit prev_stall = 0;
        logic [MW+TW+3:0] prev_out = '0;
        exp_t e;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mant = 24'h800000 >> 0;
        in_shift = 5'd1;
        in_tag = 8'hA0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if ({out_valid, out_mant, out_g, out_r, out_s, out_tag} !== prev_out) begin
                    failures++;
                    $display("FAIL stall_stable got %h required %h",
                             {out_valid, out_mant, out_g, out_r, out_s, out_tag}, prev_out);
                end
            end
            if (cyc >= 7 && !out_valid) begin
                checks++;
                failures++;
                $display("FAIL bp_gap got out_valid=0 at cycle %0d required 1", cyc);
            end
            if (!in_ready) saw_block = 1;
            if (out_valid && out_ready) begin
                checks++;
                e = sb.pop_front();
                if ({out_mant, out_g, out_r, out_s, out_tag} !== e) begin
                    failures++;
                    $display("FAIL bp_beat%0d got mant=%h grs=%b%b%b tag=%h required mant=%h grs=%b%b%b tag=%h",
                             got, out_mant, out_g, out_r, out_s, out_tag, e.mant, e.g, e.r, e.s, e.tag);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_mant, in_shift, in_tag));
                $display("bp push idx=%0d mant=%h shift=%0d tag=%h", idx, in_mant, in_shift, in_tag);
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {out_valid, out_mant, out_g, out_r, out_s, out_tag};
            @(posedge clk);
            #1;
            cyc++;
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (idx < 6) begin
                in_mant = MW'(24'h800000 | (idx * 24'h111));
                in_shift = SW'(idx * 5 + 1);
                in_tag = TW'(8'hA0 + idx);
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (!saw_block) begin
            failures++;
            $display("FAIL bp_in_ready got never low required low while full");
        end
        checks++;
        if (got != 6) begin
            failures++;
            $display("FAIL bp_count got %0d beats required 6", got);
        end
    endtask

    task automatic test_reset_midstream();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mant = 24'hABCDEF;
        in_shift = 5'd3;
        in_tag = 8'h55;
        @(posedge clk);
        #1;
        in_mant = 24'h123456;
        in_tag = 8'h66;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_inflight got out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_mant, out_g, out_r, out_s, out_tag} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got valid=%b mant=%h grs=%b%b%b tag=%h required all 0",
                     out_valid, out_mant, out_g, out_r, out_s, out_tag);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL midrst_stale got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
